// File: rtl/sha_digest_stream_rx.sv
// sha_digest_stream_rx: AXI-Stream slave that collects 16-bit SHA-3 digest beats,
// checks the beat count against the variant on TUSER, packs them into a 512-bit
// digest register and presents it with a valid/ack handshake.
// Optional feature macro: SHA_RX_DEST_FILTER_EN (drop frames whose TDEST != DEST_ID).
module sha_digest_stream_rx #(
    parameter int         DATA_WIDTH = 16,
    parameter int         MAX_BITS   = 512,
    parameter logic [7:0] DEST_ID    = 8'h00
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  TVALID,
    output logic                  TREADY,
    input  logic [DATA_WIDTH-1:0] TDATA,
    input  logic                  TLAST,
    input  logic [3:0]            TUSER,
    input  logic [1:0]            TID,
    input  logic [7:0]            TDEST,
    output logic [MAX_BITS-1:0]   digest,
    output logic [9:0]            digest_bits,
    output logic [1:0]            digest_id,
    output logic [7:0]            digest_dest,
    output logic                  digest_valid,
    input  logic                  digest_ack,
    output logic                  err_short,
    output logic                  err_long,
    output logic                  err_mode
);

    localparam int LANES = MAX_BITS / DATA_WIDTH;
    localparam int IDX_W = $clog2(LANES);

`ifdef SHA_RX_DEST_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [1:0]          mode_q;
    logic [MAX_BITS-1:0] digest_q, digest_d;
    logic [9:0]          bits_q;
    logic [1:0]          id_q;
    logic [7:0]          dest_q;
    logic                tready_q;
    logic                valid_q;
    logic                err_short_q, err_long_q, err_mode_q;
    logic                err_short_d, err_long_d, err_mode_d;
    logic                capture;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [5:0]          last_idx;
    logic [9:0]          bits_new;
    logic                accept;
    logic                dest_drop;

    assign accept    = TVALID && tready_q;
    assign dest_drop = FILTER_EN && (TDEST != DEST_ID);

    // Index of the final beat for the latched variant, and digest length for a new frame.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        last_idx = 6'd13;
        bits_new = 10'd224;
        case (mode_q)
            2'd0:    last_idx = 6'd13;
            2'd1:    last_idx = 6'd15;
            2'd2:    last_idx = 6'd23;
            default: last_idx = 6'd31;
        endcase
        case (TUSER[1:0])
            2'd0:    bits_new = 10'd224;
            2'd1:    bits_new = 10'd256;
            2'd2:    bits_new = 10'd384;
            default: bits_new = 10'd512;
        endcase
    end

    // Next-state, beat counter and error-pulse decode.
    always_comb begin
        // NOTE: combinational logic uses blocking assignments; state registers use non-blocking.
        state_d     = state_q;
        cnt_d       = cnt_q;
        capture     = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = cnt_q[IDX_W-1:0];
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        err_mode_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dest_drop) begin
                        state_d = TLAST ? IDLE : DRAIN;
                    end else if (TUSER > 4'd3) begin
                        err_mode_d = 1'b1;
                        state_d    = TLAST ? IDLE : DRAIN;
                    end else begin
                        capture = 1'b1;
                        wr_en   = 1'b1;
                        wr_idx  = '0;
                        cnt_d   = 6'd1;
                        if (TLAST) begin
                            err_short_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            state_d = COLLECT;
                        end
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == last_idx) begin
                        if (TLAST) begin
                            state_d = HOLD;
                        end else begin
                            err_long_d = 1'b1;
                            state_d    = DRAIN;
                        end
                    end else if (TLAST) begin
                        err_short_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (accept && TLAST) state_d = IDLE;
            end
            HOLD: begin
                if (digest_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Digest lane update: a new frame clears the register, then each beat fills its lane.
    always_comb begin
        digest_d = capture ? '0 : digest_q;
        if (wr_en) digest_d[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH] = TDATA;
    end

    // State, handshake outputs and error pulses, all registered.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tready_q    <= 1'b0;
            valid_q     <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            err_mode_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tready_q    <= (state_d != HOLD);
            valid_q     <= (state_d == HOLD);
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            err_mode_q  <= err_mode_d;
        end
    end

    // Frame attributes and digest storage, latched on the first beat of a legal frame.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        // NOTE: the digest register is reset because a cleared digest is a visible output value.
        if (!ARESETn) begin
            digest_q <= '0;
            mode_q   <= '0;
            bits_q   <= '0;
            id_q     <= '0;
            dest_q   <= '0;
        end else begin
            digest_q <= digest_d;
            if (capture) begin
                mode_q <= TUSER[1:0];
                bits_q <= bits_new;
                id_q   <= TID;
                dest_q <= TDEST;
            end
        end
    end

    assign TREADY       = tready_q;
    assign digest       = digest_q;
    assign digest_bits  = bits_q;
    assign digest_id    = id_q;
    assign digest_dest  = dest_q;
    assign digest_valid = valid_q;
    assign err_short    = err_short_q;
    assign err_long     = err_long_q;
    assign err_mode     = err_mode_q;

endmodule
